clock_time_keeper: RTL and testbench

CLOCK_TIME_KEEPER -- requirements
Module: clock_time_keeper

---
 rtl/clock_time_keeper_pkg.sv | 25 ++
 rtl/clock_time_keeper_bcd_digit_counter.sv | 50 +++++
 rtl/clock_time_keeper.sv | 161 ++++++++++++++++
 tb/tb_clock_time_keeper.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_time_keeper_pkg.sv
// Shared definitions for the 24-hour clock time keeper.
// Holds the blank digit code, the field-select encodings used by set_sel,
// and the BCD terminal values used to build the hour and minute digits.
package clock_time_keeper_pkg;

  // Digit code sent to a seven-segment decoder to show nothing
  localparam logic [3:0] BLANK_CODE = 4'b1111;

  // Field selected for adjustment while in time-setting mode
  typedef enum logic {
    SEL_MIN = 1'b0,
    SEL_HR  = 1'b1
  } sel_e;

  // BCD terminal values: any ones digit, minutes tens, hours tens,
  // and the hours ones digit once the hours tens digit has reached 2
  localparam logic [3:0] ONES_MAX        = 4'd9;
  localparam logic [3:0] MIN_TENS_MAX    = 4'd5;
  localparam logic [3:0] HR_TENS_MAX     = 4'd2;
  localparam logic [3:0] HR_ONES_MAX_TOP = 4'd3;

  // Default terminal value of the seconds counter
  localparam int unsigned SEC_MAX_DEFAULT = 59;

endpackage

// File: rtl/clock_time_keeper_bcd_digit_counter.sv
// One BCD digit of the clock.
// Counts 0..MAX_VAL on each enabled clock, wrapping to 0 and raising carry_o
// in the same cycle it wraps. wrap_i forces an early wrap, which lets the
// hours ones digit roll over at 3 when the hours tens digit is 2.
// Ports:
//   clk_i    - system clock
//   reset_i  - asynchronous active-high reset, digit returns to 0
//   en_i     - count enable for this cycle
//   wrap_i   - treat the current value as terminal
//   digit_o  - current BCD digit
//   carry_o  - combinational carry, high when enabled and wrapping
module bcd_digit_counter
  import clock_time_keeper_pkg::*;
#(
  parameter logic [3:0] MAX_VAL = ONES_MAX
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       wrap_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       at_top;

  // Next digit value and carry toward the next more-significant digit
  always_comb begin
    at_top  = (digit_q == MAX_VAL) || wrap_i;
    carry_o = en_i && at_top;
    digit_d = digit_q;
    if (en_i) begin
      digit_d = at_top ? 4'd0 : digit_q + 4'd1;
    end
  end

  // Digit register, cleared immediately by reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/clock_time_keeper.sv
// 24-hour BCD time keeper with time-setting mode and flashing field.
// Seconds are an internal binary counter; hours and minutes are four BCD
// digit counters. Display outputs are registered one clock behind the time
// state, with the selected field blanked on alternate flash phases.
// Ports:
//   clk_i                    - system clock
//   reset_i                  - asynchronous active-high reset
//   tick_1hz_i               - once-per-second enable pulse
//   flash_tick_i             - flash rate pulse (one per half flash period)
//   set_mode_i               - 1 = time-setting mode, 0 = run mode
//   set_sel_i                - field being set: 0 = minutes, 1 = hours
//   inc_i                    - increment pulse for the selected field
//   hr_tens_o .. min_ones_o  - BCD digits or BLANK_CODE, one per decoder
//   colon_o                  - colon separator enable
module clock_time_keeper #(
  parameter logic [3:0]  BLANK_CODE = clock_time_keeper_pkg::BLANK_CODE,
  parameter int unsigned SEC_MAX    = clock_time_keeper_pkg::SEC_MAX_DEFAULT
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_1hz_i,
  input  logic       flash_tick_i,
  input  logic       set_mode_i,
  input  logic       set_sel_i,
  input  logic       inc_i,
  output logic [3:0] hr_tens_o,
  output logic [3:0] hr_ones_o,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic       colon_o
);

  import clock_time_keeper_pkg::*;

  logic [5:0] sec_q;
  logic [5:0] sec_d;
  logic       mode_q;
  logic       sel_q;
  logic       flash_q;
  logic       flash_d;
  logic       sec_wrap;

  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic       min_ones_en;
  logic       min_ones_carry;
  logic       min_tens_carry;
  logic       hr_ones_en;
  logic       hr_ones_wrap;
  logic       hr_ones_carry;
  logic       unused_day_carry;
  logic       blank_hr;
  logic       blank_min;

  // Seconds and flash phase next state. Setting mode pins seconds at 0 and
  // ignores tick_1hz; the flash phase only runs while setting, and the
  // first set-mode cycle (mode_q still low) restarts it from visible.
  always_comb begin
    sec_wrap = !set_mode_i && tick_1hz_i && (sec_q == 6'(SEC_MAX));
    sec_d    = sec_q;
    flash_d  = 1'b0;
    if (set_mode_i) begin
      sec_d = 6'd0;
      if (mode_q && flash_tick_i) begin
        flash_d = ~flash_q;
      end else if (mode_q) begin
        flash_d = flash_q;
      end
    end else if (tick_1hz_i) begin
      sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
    end
  end

  // Digit enables: in run mode carries ripple from seconds up to hours; in
  // setting mode inc drives only the selected field and the minutes carry
  // is not allowed to reach the hours.
  always_comb begin
    min_ones_en  = sec_wrap || (set_mode_i && (set_sel_i == SEL_MIN) && inc_i);
    hr_ones_en   = (!set_mode_i && min_tens_carry) ||
                   (set_mode_i && (set_sel_i == SEL_HR) && inc_i);
    hr_ones_wrap = (hr_tens == HR_TENS_MAX) && (hr_ones == HR_ONES_MAX_TOP);
  end

  // Time state and sampled mode/select, cleared immediately by reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sec_q   <= 6'd0;
      mode_q  <= 1'b0;
      sel_q   <= 1'b0;
      flash_q <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      mode_q  <= set_mode_i;
      sel_q   <= set_sel_i;
      flash_q <= flash_d;
    end
  end

  bcd_digit_counter #(.MAX_VAL(ONES_MAX)) u_min_ones (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (min_ones_en),
    .wrap_i  (1'b0),
    .digit_o (min_ones),
    .carry_o (min_ones_carry)
  );

  bcd_digit_counter #(.MAX_VAL(MIN_TENS_MAX)) u_min_tens (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (min_ones_carry),
    .wrap_i  (1'b0),
    .digit_o (min_tens),
    .carry_o (min_tens_carry)
  );

  bcd_digit_counter #(.MAX_VAL(ONES_MAX)) u_hr_ones (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (hr_ones_en),
    .wrap_i  (hr_ones_wrap),
    .digit_o (hr_ones),
    .carry_o (hr_ones_carry)
  );

  bcd_digit_counter #(.MAX_VAL(HR_TENS_MAX)) u_hr_tens (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (hr_ones_carry),
    .wrap_i  (1'b0),
    .digit_o (hr_tens),
    .carry_o (unused_day_carry)
  );

  // The selected field blanks only while setting and in the hidden phase
  always_comb begin
    blank_hr  = mode_q && flash_q && (sel_q == SEL_HR);
    blank_min = mode_q && flash_q && (sel_q == SEL_MIN);
  end

  // Registered display outputs, one clock behind the time state. The colon
  // follows seconds parity in run mode and stays lit while setting.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hr_tens_o  <= 4'd0;
      hr_ones_o  <= 4'd0;
      min_tens_o <= 4'd0;
      min_ones_o <= 4'd0;
      colon_o    <= 1'b1;
    end else begin
      hr_tens_o  <= blank_hr  ? BLANK_CODE : hr_tens;
      hr_ones_o  <= blank_hr  ? BLANK_CODE : hr_ones;
      min_tens_o <= blank_min ? BLANK_CODE : min_tens;
      min_ones_o <= blank_min ? BLANK_CODE : min_ones;
      colon_o    <= mode_q ? 1'b1 : ~sec_q[0];
    end
  end

endmodule

// File: tb/tb_clock_time_keeper.sv
// Self-checking bench for clock_time_keeper.
// A behavioural clock model is advanced with every stimulus step and the
// display it predicts is queued; the entry is popped and compared once the
// registered outputs have had time to show the step.
module tb_clock_time_keeper;

  typedef struct {
    string       tag;
    logic [16:0] value;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       tick_1hz;
  logic       flash_tick;
  logic       set_mode;
  logic       set_sel;
  logic       inc;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic       colon;

  int   assertCount;
  int   failCount;
  exp_t expQ[$];

  int   mHr;
  int   mMin;
  int   mSec;
  bit   mMode;
  bit   mSel;
  bit   mFlash;

  clock_time_keeper dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .tick_1hz_i   (tick_1hz),
    .flash_tick_i (flash_tick),
    .set_mode_i   (set_mode),
    .set_sel_i    (set_sel),
    .inc_i        (inc),
    .hr_tens_o    (hr_tens),
    .hr_ones_o    (hr_ones),
    .min_tens_o   (min_tens),
    .min_ones_o   (min_ones),
    .colon_o      (colon)
  );

  // 10-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends with a visible failure
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [16:0] modelOut();
    logic [3:0] ht;
    logic [3:0] ho;
    logic [3:0] mt;
    logic [3:0] mo;
    logic       c;
    ht = 4'(mHr / 10);
    ho = 4'(mHr % 10);
    mt = 4'(mMin / 10);
    mo = 4'(mMin % 10);
    if (mMode && mFlash) begin
      if (mSel) begin
        ht = 4'hF;
        ho = 4'hF;
      end else begin
        mt = 4'hF;
        mo = 4'hF;
      end
    end
    c = mMode ? 1'b1 : ((mSec % 2) == 0);
    return {ht, ho, mt, mo, c};
  endfunction

  task automatic checkValue(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one step at a falling edge, advance the model, queue its display
  task automatic applyStimulus(input bit t, input bit i, input bit f, input string tag);
    exp_t e;
    if (mMode) begin
      if (i) begin
        if (mSel) mHr = (mHr + 1) % 24;
        else      mMin = (mMin + 1) % 60;
      end
      if (f) mFlash = ~mFlash;
      mSec = 0;
    end else begin
      mFlash = 1'b0;
      if (t) begin
        if (mSec == 59) begin
          mSec = 0;
          if (mMin == 59) begin
            mMin = 0;
            mHr  = (mHr + 1) % 24;
          end else begin
            mMin++;
          end
        end else begin
          mSec++;
        end
      end
    end
    tick_1hz   = t;
    inc        = i;
    flash_tick = f;
    e.tag   = tag;
    e.value = modelOut();
    expQ.push_back(e);
    @(negedge clk);
    tick_1hz   = 1'b0;
    inc        = 1'b0;
    flash_tick = 1'b0;
  endtask

  // Change mode/select as its own step and queue the resulting display
  task automatic setMode(input bit m, input bit s, input string tag);
    exp_t e;
    if (m && !mMode) begin
      mFlash = 1'b0;
      mSec   = 0;
    end
    mMode = m;
    mSel  = s;
    if (!mMode) mFlash = 1'b0;
    set_mode = m;
    set_sel  = s;
    e.tag   = tag;
    e.value = modelOut();
    expQ.push_back(e);
    @(negedge clk);
  endtask

  // One clock later the registered outputs show the step; compare them
  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    assertCount++;
    assert (expQ.size() > 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkValue(e.tag, {hr_tens, hr_ones, min_tens, min_ones, colon}, e.value);
    end
  endtask

  task automatic step(input bit t, input bit i, input bit f, input string tag);
    applyStimulus(t, i, f, tag);
    checkOutput();
  endtask

  task automatic modeStep(input bit m, input bit s, input string tag);
    setMode(m, s, tag);
    checkOutput();
  endtask

  // Directed sequence
  initial begin
    assertCount = 0;
    failCount   = 0;
    mHr = 0; mMin = 0; mSec = 0;
    mMode = 1'b0; mSel = 1'b0; mFlash = 1'b0;
    reset = 1'b1;
    tick_1hz = 1'b0; flash_tick = 1'b0; inc = 1'b0;
    set_mode = 1'b0; set_sel = 1'b0;

    #1;
    checkValue("reset_state_t1", {hr_tens, hr_ones, min_tens, min_ones, colon}, 17'h00001);
    #6;
    checkValue("reset_state_edge", {hr_tens, hr_ones, min_tens, min_ones, colon}, 17'h00001);
    @(negedge clk);
    reset = 1'b0;

    // Sixty seconds in run mode, colon alternating each tick
    for (int k = 0; k < 60; k++) step(1'b1, 1'b0, 1'b0, "run_60_ticks");

    // Run mode ignores inc and set_sel
    set_sel = 1'b1;
    step(1'b0, 1'b1, 1'b0, "run_inc_ignored");
    set_sel = 1'b0;

    // Bring the clock to 23:59:00 via set mode, then 58 + 2 ticks through midnight
    modeStep(1'b1, 1'b1, "enter_set_hours");
    for (int k = 0; k < 23; k++) step(1'b0, 1'b1, 1'b0, "set_hours_to_23");
    modeStep(1'b1, 1'b0, "select_minutes");
    for (int k = 0; k < 58; k++) step(1'b0, 1'b1, 1'b0, "set_minutes_to_59");
    modeStep(1'b0, 1'b0, "exit_set_2359");
    for (int k = 0; k < 60; k++) step(1'b1, 1'b0, 1'b0, "midnight_rollover");

    // 25 hour increments wrap 23->00 and land on 01
    modeStep(1'b1, 1'b1, "enter_set_hr25");
    for (int k = 0; k < 25; k++) step(1'b0, 1'b1, 1'b0, "set_hours_25");
    modeStep(1'b0, 1'b0, "exit_set_hr25");

    // Flashing of the minutes field and recovery on exit
    modeStep(1'b1, 1'b0, "enter_set_flash");
    step(1'b0, 1'b0, 1'b1, "flash_blank_min");
    step(1'b0, 1'b0, 1'b1, "flash_visible_min");
    step(1'b0, 1'b0, 1'b1, "flash_blank_again");
    modeStep(1'b0, 1'b0, "exit_set_visible");
    step(1'b1, 1'b0, 1'b0, "colon_after_exit");

    // Same-cycle tick and inc resolved by set_mode
    step(1'b1, 1'b1, 1'b0, "same_cycle_run");
    modeStep(1'b1, 1'b1, "enter_set_same_hr");
    step(1'b1, 1'b1, 1'b0, "same_cycle_set_hr");
    modeStep(1'b1, 1'b0, "select_min_same");
    step(1'b1, 1'b1, 1'b0, "same_cycle_set_min");

    // Set 12:34 with the minutes field blanked, then reset between edges
    modeStep(1'b1, 1'b1, "select_hours_1234");
    for (int k = 0; k < 24 && mHr != 12; k++) step(1'b0, 1'b1, 1'b0, "set_hours_12");
    modeStep(1'b1, 1'b0, "select_minutes_1234");
    for (int k = 0; k < 60 && mMin != 34; k++) step(1'b0, 1'b1, 1'b0, "set_minutes_34");
    step(1'b0, 1'b0, 1'b1, "flash_before_reset");

    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkValue("async_reset_no_edge", {hr_tens, hr_ones, min_tens, min_ones, colon}, 17'h00001);
    set_mode = 1'b0;
    set_sel  = 1'b0;
    mHr = 0; mMin = 0; mSec = 0;
    mMode = 1'b0; mSel = 1'b0; mFlash = 1'b0;
    @(negedge clk);
    checkValue("reset_held", {hr_tens, hr_ones, min_tens, min_ones, colon}, 17'h00001);
    reset = 1'b0;

    step(1'b1, 1'b0, 1'b0, "first_tick_after_reset");
    modeStep(1'b1, 1'b1, "set_after_reset_visible");
    step(1'b0, 1'b0, 1'b0, "flash_cleared_after_reset");
    modeStep(1'b0, 1'b0, "final_exit");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
